// File: rtl/sync_fa.sv
// sync_fa: registered ripple-carry full adder.
//   Each rising edge of clk captures {cout, sum} = a + b + cin, computed by a
//   ripple chain of WIDTH one-bit full-adder cells sitting between the input
//   pins and the output flops. The default WIDTH of 1 is the classic full adder.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; clears sum and cout, beats data load
//   a, b - WIDTH-bit unsigned operands (unregistered)
//   cin  - carry-in at LSB weight
//   sum  - registered low WIDTH bits of a + b + cin
//   cout - registered carry out of the MSB
module sync_fa #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   w_c;  // carry chain, w_c[0] = cin, w_c[WIDTH] = carry out
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end

  // Only an explicit rst == 1 clears; X/Z on rst falls through to the load.
  always_ff @(posedge clk) begin
    if (rst == 1'b1) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_c[WIDTH];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_sync_fa.sv
// tb_sync_fa: self-checking bench for sync_fa at WIDTH = 1, 4 and 8.
//   Directed scenarios on the 1- and 4-bit instances, then randomized traffic
//   on all three against an integer-arithmetic reference.
module tb_sync_fa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a1, b1, cin1, s1, co1;
  logic [3:0] a4, b4, s4;
  logic       cin4, co4;
  logic [7:0] a8, b8, s8;
  logic       cin8, co8;

  sync_fa #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .sum(s1), .cout(co1)
  );
  sync_fa #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(s4), .cout(co4)
  );
  sync_fa #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sum(s8), .cout(co8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {cout, sum} is simply the integer a + b + cin, which fits in WIDTH+1 bits.
  function automatic int ref_add(input int a, input int b, input int c, input bit r);
    return r ? 0 : a + b + c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input int v);
    logic [2:0] t;
    t    = v[2:0];
    a1   = t[2];
    b1   = t[1];
    cin1 = t[0];
  endtask

  int exp_tbl [9] = '{0, 1, 1, 2, 1, 2, 2, 3, 0};

  initial begin
    bit r;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;

    // Reset priority: two edges with rst high and all-ones inputs.
    tick();
    check_eq("rst_edge1_w1", {co1, s1}, 0);
    check_eq("rst_edge1_w4", {co4, s4}, 0);
    check_eq("rst_edge1_w8", {co8, s8}, 0);
    tick();
    check_eq("rst_edge2_w1", {co1, s1}, 0);
    check_eq("rst_edge2_w4", {co4, s4}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("rst_release_w1", {co1, s1}, 3);
    check_eq("rst_release_w4", {co4, s4}, 32'h1F);
    check_eq("rst_release_w8", {co8, s8}, 32'h1FF);

    // Exhaustive sweep on WIDTH=1.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set1(i % 8);
      tick();
      check_eq($sformatf("sweep_%0d", i), {co1, s1}, exp_tbl[i]);
    end

    // Registered behaviour: mid-cycle input change must not reach outputs.
    #2;
    set1(7);
    #1;
    check_eq("hold_mid_cycle", {co1, s1}, 0);
    tick();
    check_eq("load_after_edge", {co1, s1}, 3);

    // Mid-stream reset while inputs are 101.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set1(i % 8);
      rst = (i == 5);
      tick();
      check_eq($sformatf("midrst_%0d", i), {co1, s1}, (i == 5) ? 0 : exp_tbl[i]);
    end
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=4 wraparound vectors.
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    tick();
    check_eq("w4_f_plus_1", {co4, s4}, 32'h10);
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    tick();
    check_eq("w4_f_f_1", {co4, s4}, 32'h1F);
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;
    tick();
    check_eq("w4_3_4_1", {co4, s4}, 32'h08);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r    = ($urandom_range(0, 9) == 0);
      rst  = r;
      a1   = 1'($urandom);
      b1   = 1'($urandom);
      cin1 = 1'($urandom);
      a4   = 4'($urandom);
      b4   = 4'($urandom);
      cin4 = 1'($urandom);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      tick();
      check_eq("rand_w1", {co1, s1}, ref_add(int'(a1), int'(b1), int'(cin1), r));
      check_eq("rand_w4", {co4, s4}, ref_add(int'(a4), int'(b4), int'(cin4), r));
      check_eq("rand_w8", {co8, s8}, ref_add(int'(a8), int'(b8), int'(cin8), r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
